// File: rtl/busy_rr_sched_pkg.sv
// busy_rr_sched_pkg: shared state encoding and default widths for the busy-timer scheduler.
package busy_rr_sched_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
    localparam int DEF_CW     = 16;
    localparam int DEF_LGNREQ = 2;
endpackage

// File: rtl/busy_rr_sched_rr_pick.sv
// busy_rr_sched_rr_pick: rotate-priority encoder, first set request at or above ptr (mod NREQ) wins.
module busy_rr_sched_rr_pick #(
    parameter int LGNREQ = 2
) (
    input  logic [(1<<LGNREQ)-1:0] req_i,
    input  logic [LGNREQ-1:0]      ptr_i,
    output logic                   valid_o,
    output logic [LGNREQ-1:0]      win_o
);
    localparam int NREQ = 1 << LGNREQ;

    // Scan from the farthest offset down so the nearest set bit is the last to write.
    always_comb begin
        win_o = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req_i[ptr_i + LGNREQ'(i)]) win_o = ptr_i + LGNREQ'(i);
    end

    assign valid_o = |req_i;
endmodule

// File: rtl/busy_rr_sched.sv
// busy_rr_sched: round-robin owner of a single countdown busy window with a done pulse per window.
module busy_rr_sched
    import busy_rr_sched_pkg::*;
#(
    parameter int LGNREQ = DEF_LGNREQ,
    parameter int CW     = DEF_CW
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [(1<<LGNREQ)-1:0]      i_req,
    input  logic [(1<<LGNREQ)*CW-1:0]   i_len,
    output logic [(1<<LGNREQ)-1:0]      o_grant,
    output logic [LGNREQ-1:0]           o_owner,
    output logic                        o_busy,
    output logic [(1<<LGNREQ)-1:0]      o_done
);
    localparam int NREQ = 1 << LGNREQ;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, len_q, len_d, win_len;
    logic [LGNREQ-1:0] ptr_q, ptr_d, owner_q, owner_d, win;
    logic [NREQ-1:0]   grant_q, grant_d, done_q, done_d;
    logic              valid;

    busy_rr_sched_rr_pick #(.LGNREQ(LGNREQ)) u_pick (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .valid_o (valid),
        .win_o   (win)
    );

    // A zero length still occupies the resource for one cycle.
    assign win_len = (i_len[win*CW +: CW] == '0) ? CW'(1) : i_len[win*CW +: CW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        owner_d = owner_q;
        done_d  = '0;
        if (state_q == IDLE) begin
            if (valid) begin
                state_d = RUN;
                cnt_d   = win_len;
                len_d   = win_len;
                ptr_d   = win + LGNREQ'(1);
                grant_d = NREQ'(1) << win;
                owner_d = win;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                grant_d = '0;
                done_d  = grant_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            owner_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            done_q  <= done_d;
        end
    end

    assign o_grant = grant_q;
    assign o_owner = owner_q;
    assign o_busy  = (state_q == RUN);
    assign o_done  = done_q;

    a_grant_1h:  assert property (@(posedge i_clk) disable iff (i_reset) $onehot0(grant_q));
    a_busy_eq:   assert property (@(posedge i_clk) disable iff (i_reset) (o_busy == |grant_q) && (o_busy == (cnt_q != '0)));
    a_done_1h:   assert property (@(posedge i_clk) disable iff (i_reset) $onehot0(done_q) && !(|done_q && o_busy));
    a_cnt_le:    assert property (@(posedge i_clk) disable iff (i_reset) cnt_q <= len_q);
    a_grant_stb: assert property (@(posedge i_clk) disable iff (i_reset) (state_q == RUN && cnt_q != CW'(1)) |=> $stable(grant_q));
endmodule

// File: tb/tb_busy_rr_sched.sv
// tb_busy_rr_sched: directed checks of grant order, window length, done pulse and reset abort.
module tb_busy_rr_sched;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [3:0]  i_req;
    logic [63:0] i_len;
    logic [3:0]  o_grant;
    logic [1:0]  o_owner;
    logic        o_busy;
    logic [3:0]  o_done;
    int          checks = 0;
    int          errors = 0;

    busy_rr_sched #(.LGNREQ(2), .CW(16)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   (i_req),
        .i_len   (i_len),
        .o_grant (o_grant),
        .o_owner (o_owner),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_req   = '0;
        step();
        step();
        i_reset = 1'b0;
        check("rst_grant", 32'(o_grant), 0);
        check("rst_owner", 32'(o_owner), 0);
        check("rst_busy",  32'(o_busy), 0);
        check("rst_done",  32'(o_done), 0);
    endtask

    // Requests already applied; walks one window of l cycles for winner w, then its done cycle.
    task automatic window(input int w, input int l, input logic [3:0] req_after, input logic [63:0] len_after);
        for (int c = 1; c <= l; c++) begin
            step();
            if (c == 1) begin
                i_req = req_after;
                i_len = len_after;
            end
            check($sformatf("w%0d_grant_c%0d", w, c), 32'(o_grant), 32'(4'b1 << w));
            check($sformatf("w%0d_busy_c%0d", w, c), 32'(o_busy), 1);
            check($sformatf("w%0d_owner_c%0d", w, c), 32'(o_owner), 32'(w));
            check($sformatf("w%0d_done_c%0d", w, c), 32'(o_done), 0);
        end
        step();
        check($sformatf("w%0d_done", w), 32'(o_done), 32'(4'b1 << w));
        check($sformatf("w%0d_end_grant", w), 32'(o_grant), 0);
        check($sformatf("w%0d_end_busy", w), 32'(o_busy), 0);
        check($sformatf("w%0d_end_owner", w), 32'(o_owner), 32'(w));
    endtask

    initial begin
        i_len = '0;
        step();
        do_reset();

        // 1: single requester 1, length 3
        i_len[16 +: 16] = 16'd3;
        i_req = 4'b0010;
        window(1, 3, 4'b0000, i_len);
        step();
        check("t1_done_clear", 32'(o_done), 0);
        check("t1_owner_hold", 32'(o_owner), 1);

        // 2: all requesting, all length 2, order from pointer 0
        do_reset();
        i_len = {16'd2, 16'd2, 16'd2, 16'd2};
        i_req = 4'b1111;
        window(0, 2, 4'b1111, i_len);
        window(1, 2, 4'b1111, i_len);
        window(2, 2, 4'b1111, i_len);
        window(3, 2, 4'b1111, i_len);
        i_req = 4'b1111;
        window(0, 2, 4'b1111, i_len);
        i_req = 4'b0000;
        step();
        check("t2_idle_busy", 32'(o_busy), 0);

        // 3: pointer at 3 after grant to 2, then 3 wins and pointer wraps to 0
        do_reset();
        i_req = 4'b0100;
        window(2, 2, 4'b0000, i_len);
        i_req = 4'b1001;
        window(3, 2, 4'b1001, i_len);
        window(0, 2, 4'b0000, i_len);

        // 4: zero length acts as one; mid-window length change ignored
        do_reset();
        i_len[0 +: 16] = 16'd0;
        i_req = 4'b0001;
        window(0, 1, 4'b0000, i_len);
        i_len[0 +: 16] = 16'd5;
        i_req = 4'b0001;
        window(0, 5, 4'b0000, {i_len[63:16], 16'd9});

        // 5a: request dropped after one cycle of a 6-cycle window
        do_reset();
        i_len[16 +: 16] = 16'd6;
        i_req = 4'b0010;
        window(1, 6, 4'b0000, i_len);

        // 5b: reset mid-window aborts with no done, pointer back to 0
        i_len[32 +: 16] = 16'd6;
        i_req = 4'b0100;
        step();
        check("t5_grant2", 32'(o_grant), 32'(4'b0100));
        step();
        i_reset = 1'b1;
        step();
        check("t5_rst_grant", 32'(o_grant), 0);
        check("t5_rst_busy", 32'(o_busy), 0);
        check("t5_rst_done", 32'(o_done), 0);
        check("t5_rst_owner", 32'(o_owner), 0);
        i_reset = 1'b0;
        i_req = 4'b1111;
        step();
        check("t5_post_done", 32'(o_done), 0);
        check("t5_ptr0_grant", 32'(o_grant), 32'(4'b0001));
        check("t5_ptr0_owner", 32'(o_owner), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
